// File: rtl/div_ctrl.sv
// Sequencer for the iterative divider: launches a divide, stalls the control
// unit, retires quotient/remainder into LO/HI, and flags divide-by-zero or a hung divider.
module div_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        stall,
    output logic        ack,
    output logic        dbz_exc,
    output logic        timeout_err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        div_rst,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_busy,
    input  logic        div_done,
    input  logic        div_dbz,
    input  logic [31:0] div_val,
    input  logic [31:0] div_rem
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [CW-1:0] cnt_reg;
    logic          timed_out;

    // Busy is status only; a start issued while busy is caught by the timeout.
    logic unused_busy;
    assign unused_busy = div_busy;

    assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (div_done || timed_out) state_next = S_CLEAR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            hi          <= '0;
            lo          <= '0;
            div_a       <= '0;
            div_b       <= '0;
            ack         <= 1'b0;
            dbz_exc     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack       <= 1'b0;
            dbz_exc   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        div_a   <= op_a;
                        div_b   <= op_b;
                        cnt_reg <= '0;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    // A done arriving on the last allowed cycle beats the timeout.
                    if (div_done) begin
                        if (div_dbz) begin
                            dbz_exc <= 1'b1;
                        end else begin
                            lo  <= div_val;
                            hi  <= div_rem;
                            ack <= 1'b1;
                        end
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_start = (state_reg == S_START);
    assign div_rst   = rst || (state_reg == S_CLEAR);
    assign stall     = (state_reg == S_START) || (state_reg == S_WAIT) ||
                       ((state_reg == S_IDLE) && req);

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized scoreboard bench for div_ctrl with a behavioural 32-iteration divider.
module tb_div_ctrl;

    localparam int TIMEOUT = 64;
    localparam int K_ACK = 0;
    localparam int K_DBZ = 1;
    localparam int K_TMO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] op_a, op_b;
    logic        stall, ack, dbz_exc, timeout_err;
    logic [31:0] hi, lo;
    logic        div_start, div_rst;
    logic [31:0] div_a, div_b;
    logic        div_busy = 1'b0;
    logic        div_done = 1'b0;
    logic        div_dbz  = 1'b0;
    logic [31:0] div_val  = '0;
    logic [31:0] div_rem  = '0;

    div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .stall(stall), .ack(ack), .dbz_exc(dbz_exc), .timeout_err(timeout_err),
        .hi(hi), .lo(lo), .div_start(div_start), .div_rst(div_rst),
        .div_a(div_a), .div_b(div_b), .div_busy(div_busy), .div_done(div_done),
        .div_dbz(div_dbz), .div_val(div_val), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider: done first visible 34 cycles after the start edge; dbz is immediate.
    bit hang_mode = 1'b0;
    int dcnt = 0;
    always @(posedge clk) begin
        if (div_rst) begin
            div_busy <= 1'b0; div_done <= 1'b0; div_dbz <= 1'b0; dcnt <= 0;
        end else if (div_start && !div_busy && !div_done) begin
            if (div_b == 32'd0) begin
                div_done <= 1'b1; div_dbz <= 1'b1;
            end else begin
                div_busy <= 1'b1;
                dcnt     <= 1;
                div_val  <= $signed(div_a) / $signed(div_b);
                div_rem  <= $signed(div_a) % $signed(div_b);
            end
        end else if (div_busy && !hang_mode) begin
            dcnt <= dcnt + 1;
            if (dcnt == 33) begin
                div_done <= 1'b1; div_busy <= 1'b0;
            end
        end
    end

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int n_ack = 0;
    int n_dbz = 0;
    logic [31:0] ref_lo = '0;
    logic [31:0] ref_hi = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every ack, dbz pulse or new timeout retires the oldest expectation.
    bit prev_tmo = 1'b0;
    int kind;
    exp_t e_mon;
    always @(negedge clk) begin
        if (ack || dbz_exc || (timeout_err && !prev_tmo)) begin
            kind = ack ? K_ACK : (dbz_exc ? K_DBZ : K_TMO);
            if (ack) n_ack++;
            if (dbz_exc) n_dbz++;
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got kind %0d at cycle %0d, required no response", kind, cyc);
            end else begin
                e_mon = q.pop_front();
                chk("resp_kind", kind, e_mon.kind);
                chk("resp_cycle", cyc, e_mon.cyc);
                chk("lo", lo, e_mon.lo);
                chk("hi", hi, e_mon.hi);
                $display("resp kind=%0d cycle=%0d lo=0x%08h hi=0x%08h", kind, cyc, lo, hi);
            end
        end
        prev_tmo = timeout_err;
    end

    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the following IDLE cycle.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit hang, input bit hold);
        exp_t e;
        int c0, lat;
        int n_stall = 0, n_start = 0, n_rst = 0;
        bit done = 1'b0;
        op_a = a; op_b = b; hang_mode = hang; req = 1'b1; c0 = cyc;
        if (b == 32'd0) begin
            lat = 3;
            e = '{K_DBZ, c0 + 3, ref_lo, ref_hi};
        end else if (hang) begin
            lat = TIMEOUT + 2;
            e = '{K_TMO, c0 + TIMEOUT + 2, ref_lo, ref_hi};
        end else begin
            lat = 36;
            ref_lo = $signed(a) / $signed(b);
            ref_hi = $signed(a) % $signed(b);
            e = '{K_ACK, c0 + 36, ref_lo, ref_hi};
        end
        q.push_back(e);
        $display("issue a=0x%08h b=0x%08h hang=%0d cycle=%0d", a, b, hang, c0);
        #1;
        chk("stall_on_req", stall, 1'b1);
        for (int k = 0; k < 200; k++) begin
            if (k == 1) begin
                chk("div_a", div_a, a);
                chk("div_b", div_b, b);
            end
            if (stall) n_stall++;
            if (div_start) n_start++;
            if (div_rst) n_rst++;
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk); #1;
            if (!hold) req = 1'b0;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_bound: got no response within 200 cycles, required one");
            q.delete();
        end
        chk("stall_cycles", n_stall, lat);
        chk("start_pulses", n_start, 1);
        chk("rst_pulses", n_rst, 1);
        @(negedge clk); #1;
    endtask

    logic [31:0] ra, rb;
    int a0, d0;

    initial begin
        rst = 1'b0; req = 1'b0; op_a = '0; op_b = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dbz", dbz_exc, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_div_rst", div_rst, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, 1'b0);
        do_div(32'd55, 32'd0, 1'b0, 1'b0);
        do_div(32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);

        do_div(32'd20, 32'd3, 1'b0, 1'b1);
        do_div(32'd9, 32'd4, 1'b0, 1'b0);

        do_div(32'd50, 32'd5, 1'b1, 1'b0);
        chk("tmo_sticky", timeout_err, 1'b1);
        do_div(32'd77, 32'd8, 1'b0, 1'b0);
        chk("tmo_sticky_after", timeout_err, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra = ra % 5000;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            do_div(ra, rb, 1'b0, 1'b0);
        end

        // Abort in the 10th WAIT cycle: nothing may be retired for this request.
        op_a = 32'd1000; op_b = 32'd3; hang_mode = 1'b0; req = 1'b1;
        @(negedge clk); #1;
        req = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("stall_mid_op", stall, 1'b1);
        a0 = n_ack; d0 = n_dbz;
        rst = 1'b1;
        #1;
        ref_lo = '0; ref_hi = '0;
        chk("abort_stall", stall, 1'b0);
        chk("abort_ack", ack, 1'b0);
        chk("abort_dbz", dbz_exc, 1'b0);
        chk("abort_tmo", timeout_err, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_div_a", div_a, 32'd0);
        chk("abort_div_b", div_b, 32'd0);
        chk("abort_div_start", div_start, 1'b0);
        chk("abort_div_rst", div_rst, 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("div_rst_held", div_rst, 1'b1);
        end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("no_ack_after_abort", n_ack - a0, 0);
        chk("no_dbz_after_abort", n_dbz - d0, 0);
        chk("idle_after_abort", stall, 1'b0);

        do_div(32'd1000, 32'd10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the multicycle datapath's iterative divider. It accepts a divide request from the main control unit and drives the divider's start/reset handshake. It stalls the control unit until the result is ready, then loads quotient and remainder into the architectural LO/HI registers. It also converts divide-by-zero into a one-cycle exception pulse and guards against a hung divider with a timeout.

## Interface
- TIMEOUT, default 64: maximum cycles spent in WAIT before aborting; must be ≥ 40.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  divide request from control unit; level, sampled only in IDLE.
- op_a  in  32  dividend (signed).
- op_b  in  32  divisor (signed).
- stall  out  1  freeze control unit; combinational.
- ack  out  1  one-cycle pulse: HI/LO updated with a valid result.
- dbz_exc  out  1  one-cycle pulse: divisor was zero; HI/LO unchanged.
- timeout_err  out  1  sticky error flag; cleared only by rst.
- hi  out  32  remainder register.
- lo  out  32  quotient register.
- div_start  out  1  divider start strobe.
- div_rst  out  1  divider synchronous clear.
- div_a, div_b  out  32  latched operands to divider.
- div_busy, div_done, div_dbz  in  1  divider status; div_done is sticky until div_rst.
- div_val, div_rem  in  32  divider quotient and remainder, valid when div_done=1.

## Operation
- States: IDLE, START, WAIT, CLEAR; encoded registered FSM.
- IDLE:
  - req=1 → latch op_a/op_b into div_a/div_b, clear cycle counter, go to START.
  - req=0 → stay in IDLE.
- START: div_start=1 for exactly this cycle → go to WAIT.
- WAIT: div_start=0; counter increments each cycle.
  - div_done=1 and div_dbz=0 → lo←div_val, hi←div_rem at this edge, set ack flag → go to CLEAR.
  - div_done=1 and div_dbz=1 → set dbz flag, HI/LO untouched → go to CLEAR.
  - counter reaches TIMEOUT−1 with no done → timeout_err←1, HI/LO untouched → go to CLEAR.
  - div_done and timeout in the same cycle → done wins; timeout_err is not set.
- CLEAR: div_rst=1 (clears the divider's sticky done). ack or dbz_exc is high this cycle only. → go to IDLE.
- stall = (state≠IDLE && state≠CLEAR) || (state==IDLE && req).
  - The control unit freezes in the same cycle it raises req and resumes in the CLEAR cycle.
- The control unit must drop req in the CLEAR cycle. If req is still high in the following IDLE cycle, a new divide starts.
- div_busy is informational only. If div_busy=1 in IDLE, start is still issued; the divider ignores start while busy or done, so the timeout catches any resulting hang.
- Async reset: state=IDLE, hi=lo=0, div_a=div_b=0, ack=dbz_exc=timeout_err=0, div_start=0, counter=0.
  - div_rst = rst || state==CLEAR, so the divider is held clear during reset.
- Reset mid-operation aborts immediately. No partial HI/LO update occurs, and no ack is ever produced for the aborted request.

## Timing
- Cycle 0: IDLE with req=1; stall=1 combinationally.
- Cycle 1: START.
- Cycles 2..: WAIT. With the team's 32-iteration divider, div_done is first high in cycle 35 (34th WAIT cycle), and HI/LO are written at the end of cycle 35.
- Cycle 36: CLEAR, ack=1, stall=0.
- Cycle 37: IDLE.
- Divide-by-zero: div_done/div_dbz are visible in cycle 2. Cycle 3 is CLEAR with dbz_exc=1.
- Back-to-back: the earliest next req acceptance is cycle 37, i.e. a 37-cycle issue interval.
- Timeout: with TIMEOUT=64, WAIT spans cycles 2–65, CLEAR is cycle 66, and timeout_err=1 from cycle 66 onward.

## Test plan
- Positive operands: op_a=100, op_b=7 → ack in cycle 36; lo=14, hi=2; stall high cycles 0–35; exactly one div_start pulse and one div_rst pulse.
- Signed operands: op_a=−100 (0xFFFFFF9C), op_b=7 → lo=0xFFFFFFF2 (−14), hi as returned by the divider. The controller passes values through unmodified.
- Divide by zero: op_b=0 → dbz_exc=1 in cycle 3, ack never asserted, hi/lo retain their prior values (e.g. 2/14 from the previous test).
- Hung divider: model that never asserts div_done, TIMEOUT=64 → timeout_err=1 from cycle 66 and stays high; FSM returns to IDLE and accepts the next req.
- Reset mid-operation: assert rst asynchronously in WAIT cycle 10 → all outputs at reset values before the next edge, div_rst=1 while rst is held, no ack or dbz_exc follows.
- Held req: keep req=1 across two divisions (20/3 then 9/4) → two acks in cycles 36 and 73, lo/hi=6/2 then 2/1.
